// File: rtl/sync_dr_tx.sv
// sync_dr_tx: takes words from a clocked valid/ready source and drives them onto a
// dual-rail asynchronous link. It uses either two-phase (TP) or four-phase
// return-to-zero (FP) signalling. The asynchronous ack is synchronised before the
// FSM uses it.
//
// state      | meaning
// ST_IDLE    | no token outstanding; accepts a word when the synchronised ack is at rest
// ST_WAIT_HI | token on the link; FP waits for ack_s=1, TP waits for ack_s!=ph
// ST_WAIT_LO | FP only: spacer on the link, waiting for ack_s=0
module sync_dr_tx #(
  parameter ENC = "TP",
  parameter int WIDTH = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0][1:0] out,
  input  logic                  ack,
  output logic                  busy,
  output logic                  err
);

  // Any encoding other than "FP" is treated as two-phase.
  localparam logic IS_FP = (ENC == "FP");

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_s;
  logic                    ack_s_pre;
  logic [1:0]              state;
  logic                    ph;
  logic                    accept;
  logic                    rest_ok;
  logic                    bad_now;
  logic                    bad_pre;
  logic                    err_set;
  logic [WIDTH-1:0][1:0]   tok;

  // Synchroniser for the asynchronous ack; only the last stage reaches the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
    end
  end

  assign ack_s     = sync_q[SYNC_STAGES-1];
  // The value ack_s will take at the next edge. This catches an ack change that
  // lands on the same edge as an accept.
  assign ack_s_pre = sync_q[SYNC_STAGES-2];

  // One-hot rail pattern for the incoming word: the true rail for a 1, the false rail for a 0.
  always_comb begin
    tok = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tok[i][in_data[i]] = 1'b1;
    end
  end

  // Handshake qualifiers and protocol-error detection.
  always_comb begin
    rest_ok  = IS_FP ? ~ack_s : (ack_s == ph);
    in_ready = (state == ST_IDLE) & rest_ok;
    accept   = in_valid & in_ready;
    busy     = (state != ST_IDLE);
    bad_now  = IS_FP ? ack_s : (ack_s != ph);
    bad_pre  = IS_FP ? ack_s_pre : (ack_s_pre != ph);
    err_set  = (state == ST_IDLE) & (bad_now | (accept & bad_pre));
  end

  // Protocol sequencer. The link output is registered and changes only here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      out   <= '0;
      ph    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            out   <= IS_FP ? tok : (out ^ tok);
            state <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (IS_FP) begin
            if (ack_s) begin
              out   <= '0;
              state <= ST_WAIT_LO;
            end
          end else if (ack_s != ph) begin
            ph    <= ~ph;
            state <= ST_IDLE;
          end
        end
        ST_WAIT_LO: begin
          if (!ack_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_dr_tx.sv
// Bench for sync_dr_tx. It builds three configurations: FP/8/2, TP/4/2 and FP/8/3.
// Each one has a completion-echo ack and a token-level reference model.
module tb_sync_dr_tx;

  logic clk = 1'b0;
  logic rst;
  logic       in_valid_a [3];
  logic [7:0] in_data_a  [3];
  logic       force_en   [3];
  logic       force_val  [3];
  int n_pass;
  int n_total;
  int cyc = 0;
  bit done;

  always #5 clk = ~clk;

  // Count of rising edges, so that accept times can be measured.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam bit FP = (g != 1);
    localparam int W  = (g == 1) ? 4 : 8;
    localparam int S  = (g == 2) ? 3 : 2;

    logic                in_ready, busy, err, ack, all_set;
    logic [W-1:0][1:0]   dout;
    logic [15:0]         out16;
    logic [18:0]         act_v, exp_v;

    if (FP) begin : g_fp
      sync_dr_tx #(.ENC("FP"), .WIDTH(W), .SYNC_STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data_a[g][W-1:0]), .in_valid(in_valid_a[g]),
        .in_ready(in_ready), .out(dout), .ack(ack), .busy(busy), .err(err));
    end else begin : g_tp
      sync_dr_tx #(.ENC("TP"), .WIDTH(W), .SYNC_STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data_a[g][W-1:0]), .in_valid(in_valid_a[g]),
        .in_ready(in_ready), .out(dout), .ack(ack), .busy(busy), .err(err));
    end

    assign out16 = 16'(dout);

    // Completion detector: FP sees every bit valid; TP sees the token parity on bit 0.
    always_comb begin
      all_set = 1'b1;
      for (int i = 0; i < W; i++) all_set = all_set & (dout[i][1] | dout[i][0]);
    end
    assign ack = force_en[g] ? force_val[g] : (FP ? all_set : (dout[0][1] ^ dout[0][0]));

    // Reference model. It tracks outstanding tokens, the FP spacer phase and the TP
    // rail parity (each TP token flips one rail per bit).
    logic [S-1:0] m_hist, n_hist;
    logic m_outst, n_outst, m_spacer, n_spacer, m_ph, n_ph, m_err, n_err;
    logic m_ready, m_acc, a_s, a_n;
    logic [15:0] m_tok, n_tok, m_par, n_par;

    always_comb begin
      n_hist   = {m_hist[S-2:0], ack};
      n_outst  = m_outst;
      n_spacer = m_spacer;
      n_ph     = m_ph;
      n_err    = m_err;
      n_tok    = m_tok;
      n_par    = m_par;
      a_s      = m_hist[S-1];
      a_n      = m_hist[S-2];
      m_ready  = !m_outst && (FP ? !a_s : (a_s == m_ph));
      m_acc    = in_valid_a[g] && m_ready;
      if (!m_outst && (FP ? (a_s || (m_acc && a_n)) : ((a_s != m_ph) || (m_acc && (a_n != m_ph)))))
        n_err = 1'b1;
      if (m_acc) begin
        n_outst  = 1'b1;
        n_spacer = 1'b0;
        n_tok    = '0;
        for (int i = 0; i < W; i++) begin
          n_tok[2*i + int'(in_data_a[g][i])] = 1'b1;
          n_par[2*i + int'(in_data_a[g][i])] = ~m_par[2*i + int'(in_data_a[g][i])];
        end
      end else if (m_outst) begin
        if (FP) begin
          if (!m_spacer && a_s) n_spacer = 1'b1;
          else if (m_spacer && !a_s) n_outst = 1'b0;
        end else if (a_s != m_ph) begin
          n_ph    = ~m_ph;
          n_outst = 1'b0;
        end
      end
    end

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_hist <= '0; m_outst <= 1'b0; m_spacer <= 1'b0; m_ph <= 1'b0;
        m_err <= 1'b0; m_tok <= '0; m_par <= '0;
      end else begin
        m_hist <= n_hist; m_outst <= n_outst; m_spacer <= n_spacer; m_ph <= n_ph;
        m_err <= n_err; m_tok <= n_tok; m_par <= n_par;
      end
    end

    assign act_v = {err, busy, in_ready, out16};
    assign exp_v = {m_err, m_outst, m_ready,
                    FP ? ((m_outst && !m_spacer) ? m_tok : 16'h0) : m_par};
  end

  function automatic logic [18:0] act_vec(input int k);
    case (k)
      0: return g_cfg[0].act_v;
      1: return g_cfg[1].act_v;
      default: return g_cfg[2].act_v;
    endcase
  endfunction

  function automatic logic [18:0] exp_vec(input int k);
    case (k)
      0: return g_cfg[0].exp_v;
      1: return g_cfg[1].exp_v;
      default: return g_cfg[2].exp_v;
    endcase
  endfunction

  function automatic logic [15:0] get_out(input int k);
    logic [18:0] v;
    v = act_vec(k);
    return v[15:0];
  endfunction

  function automatic logic get_ready(input int k);
    logic [18:0] v;
    v = act_vec(k);
    return v[16];
  endfunction

  function automatic logic get_busy(input int k);
    logic [18:0] v;
    v = act_vec(k);
    return v[17];
  endfunction

  function automatic logic get_err(input int k);
    logic [18:0] v;
    v = act_vec(k);
    return v[18];
  endfunction

  function automatic logic [15:0] enc(input logic [7:0] d, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[2*i + int'(d[i])] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cmp_inst(input int k);
    logic [18:0] a, e;
    a = act_vec(k);
    e = exp_vec(k);
    check($sformatf("cfg%0d out", k),      32'(a[15:0]), 32'(e[15:0]));
    check($sformatf("cfg%0d in_ready", k), 32'(a[16]),   32'(e[16]));
    check($sformatf("cfg%0d busy", k),     32'(a[17]),   32'(e[17]));
    check($sformatf("cfg%0d err", k),      32'(a[18]),   32'(e[18]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and return the cycle number of the accept edge, or -1 on timeout.
  task automatic send(input int k, input logic [7:0] d, output int c);
    in_valid_a[k] = 1'b1;
    in_data_a[k]  = d;
    c = -1;
    for (int n = 0; n < 100; n++) begin
      if (get_ready(k)) begin
        tick();
        c = cyc;
        break;
      end
      tick();
    end
    in_valid_a[k] = 1'b0;
    check($sformatf("cfg%0d accept timeout", k), 32'(c >= 0), 32'd1);
  endtask

  task automatic wait_spacer(input int k, output int n);
    n = 0;
    while (get_out(k) != 16'h0 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!get_ready(k) && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("cfg%0d ready timeout", k), 32'(get_ready(k)), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c1, c2, n, viol, nacc;
    logic [7:0] acc_word;
    logic pending;
    rst = 1'b1;
    done = 1'b0;
    n_pass = 0;
    n_total = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid_a[k] = 1'b0; in_data_a[k] = '0; force_en[k] = 1'b0; force_val[k] = 1'b0;
    end
    fork
      begin
        #1 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("cfg%0d reset out", k),   32'(get_out(k)),   32'd0);
          check($sformatf("cfg%0d reset ready", k), 32'(get_ready(k)), 32'd1);
          check($sformatf("cfg%0d reset busy", k),  32'(get_busy(k)),  32'd0);
          check($sformatf("cfg%0d reset err", k),   32'(get_err(k)),   32'd0);
        end
        #10 rst = 1'b1;
        tick();

        // FP, 8 bits: single token 0xA5, then minimum period.
        send(0, 8'hA5, c1);
        check("fp a5 token", 32'(get_out(0)), 32'h9966);
        check("fp a5 busy", 32'(get_busy(0)), 32'd1);
        check("fp a5 ready", 32'(get_ready(0)), 32'd0);
        wait_spacer(0, n);
        check("fp spacer edges", n, 3);
        wait_ready(0);
        check("fp idle busy", 32'(get_busy(0)), 32'd0);
        check("fp a5 err", 32'(get_err(0)), 32'd0);
        send(0, 8'h3C, c1);
        send(0, 8'hC3, c2);
        check("fp period", c2 - c1, 7);
        wait_ready(0);

        // TP, 4 bits: 0x3 twice toggles the same rails up and back down.
        send(1, 8'h03, c1);
        check("tp first token", 32'(get_out(1)), 32'h5A);
        send(1, 8'h03, c2);
        check("tp second token", 32'(get_out(1)), 32'h00);
        check("tp period", c2 - c1, 4);
        wait_ready(1);
        check("tp ph final", 32'(g_cfg[1].g_tp.u_dut.ph), 32'd0);

        // FP back-pressure: data changes every cycle; only accept-edge words go out.
        viol = 0;
        nacc = 0;
        pending = 1'b0;
        acc_word = '0;
        in_valid_a[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
          in_data_a[0] = 8'(i * 37 + 11);
          if (get_busy(0) && get_ready(0)) viol++;
          pending = get_ready(0);
          if (pending) acc_word = in_data_a[0];
          tick();
          if (pending) begin
            nacc++;
            check("bp sent word", 32'(get_out(0)), 32'(enc(acc_word, 8)));
          end
        end
        in_valid_a[0] = 1'b0;
        check("bp ready during wait", viol, 0);
        check("bp accept count", nacc, 6);
        wait_ready(0);

        // Asynchronous reset while FP is parked in WAIT_HI.
        force_en[0] = 1'b1;
        force_val[0] = 1'b0;
        send(0, 8'hC3, c1);
        tick();
        tick();
        check("rst pre busy", 32'(get_busy(0)), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst async out", 32'(get_out(0)), 32'd0);
        check("rst async busy", 32'(get_busy(0)), 32'd0);
        check("rst async ready", 32'(get_ready(0)), 32'd1);
        #2 rst = 1'b1;
        force_en[0] = 1'b0;
        tick();
        send(0, 8'h5A, c1);
        check("rst new token", 32'(get_out(0)), 32'h6699);
        wait_spacer(0, n);
        wait_ready(0);
        check("rst new err", 32'(get_err(0)), 32'd0);

        // Spurious ack pulse on the idle TP link.
        check("spur err before", 32'(get_err(1)), 32'd0);
        force_en[1] = 1'b1;
        force_val[1] = 1'b1;
        tick();
        force_en[1] = 1'b0;
        check("spur err e", 32'(get_err(1)), 32'd0);
        tick();
        check("spur err e+1", 32'(get_err(1)), 32'd0);
        tick();
        check("spur err e+2", 32'(get_err(1)), 32'd1);
        repeat (10) tick();
        check("spur err sticky", 32'(get_err(1)), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("spur err reset", 32'(get_err(1)), 32'd0);
        #2 rst = 1'b1;
        tick();

        // FP with three synchroniser stages.
        send(2, 8'h81, c1);
        check("s3 token", 32'(get_out(2)), 32'h9556);
        wait_spacer(2, n);
        check("s3 spacer edges", n, 4);
        wait_ready(2);
        send(2, 8'h0F, c1);
        send(2, 8'hF0, c2);
        check("s3 period", c2 - c1, 9);
        wait_ready(2);
        check("s3 err", 32'(get_err(2)), 32'd0);

        tick();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (rst && !done) begin
            cmp_inst(0);
            cmp_inst(1);
            cmp_inst(2);
          end
        end
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
